// File: rtl/execute_sys_reg_ctrl.sv
// execute_sys_reg_ctrl
//
// Sequencer around the combinational system-register datapath in the execute
// stage. It takes one instruction at a time from dispatch and registers its
// operands. It drives those operands into the datapath and captures the result.
// The result goes to writeback under a valid/lock handshake. IDT and PSR updates
// also pulse a one-cycle commit strobe and then hold a reload request to fetch
// until fetch acknowledges it.
//
// Ports
//   iCLOCK, inRESET           clock, asynchronous active-low reset
//   iEVENT_FLUSH              abort from exception logic (ignored once in RELOAD)
//   iPREVIOUS_*/oPREVIOUS_LOCK  dispatch side: instruction in, busy back
//   oSYSREG_*/iSYSREG_*       datapath side: latched operands out, result in
//   oIDT_SET_VALID, oPSR_SET_VALID, oSET_DATA   commit strobes and data
//   oNEXT_*/iNEXT_LOCK        writeback side
//   oBRANCH_REQ/ADDR, iBRANCH_ACK               pipeline reload to fetch
module execute_sys_reg_ctrl #(
  parameter logic [31:0] P_PC_INC = 32'h4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iEVENT_FLUSH,
  input  logic        iPREVIOUS_VALID,
  output logic        oPREVIOUS_LOCK,
  input  logic [4:0]  iPREVIOUS_CMD,
  input  logic [31:0] iPREVIOUS_PC,
  input  logic [31:0] iPREVIOUS_SOURCE0,
  input  logic [31:0] iPREVIOUS_SOURCE1,
  input  logic [4:0]  iPREVIOUS_DESTINATION,
  input  logic        iPREVIOUS_WRITEBACK,
  output logic [4:0]  oSYSREG_CMD,
  output logic [31:0] oSYSREG_PC,
  output logic [31:0] oSYSREG_SOURCE0,
  output logic [31:0] oSYSREG_SOURCE1,
  input  logic [31:0] iSYSREG_OUT,
  input  logic        iSYSREG_IDT_VALID,
  input  logic        iSYSREG_PSR_VALID,
  input  logic [31:0] iSYSREG_RELOAD_ADDR,
  output logic        oIDT_SET_VALID,
  output logic        oPSR_SET_VALID,
  output logic [31:0] oSET_DATA,
  output logic        oNEXT_VALID,
  input  logic        iNEXT_LOCK,
  output logic [31:0] oNEXT_DATA,
  output logic [4:0]  oNEXT_DESTINATION,
  output logic        oNEXT_WRITEBACK,
  output logic        oBRANCH_REQ,
  output logic [31:0] oBRANCH_ADDR,
  input  logic        iBRANCH_ACK
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    WB     = 2'd2,
    RELOAD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  cmd_q;
  logic [31:0] pc_q;
  logic [31:0] src0_q;
  logic [31:0] src1_q;
  logic [4:0]  dest_q;
  logic        wb_q;
  logic [31:0] result_q;
  logic [31:0] branch_addr_q;
  logic        idt_strobe_q;
  logic        psr_strobe_q;
  logic        reload_pending_q;

  logic        accept;
  logic        exec_commit;

  // Flush beats accept. A flushed EXEC commits nothing: no result, no strobe,
  // no reload.
  assign accept      = (state == IDLE) && iPREVIOUS_VALID && !iEVENT_FLUSH;
  assign exec_commit = (state == EXEC) && !iEVENT_FLUSH;

  // NOTE: always_ff state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        state_next = iEVENT_FLUSH ? IDLE : WB;
      end
      WB: begin
        if (iEVENT_FLUSH)     state_next = IDLE;
        else if (!iNEXT_LOCK) state_next = reload_pending_q ? RELOAD : IDLE;
      end
      RELOAD: begin
        // The architectural update has already happened, so a flush cannot
        // cancel it. Only the fetch acknowledge ends the reload.
        if (iBRANCH_ACK) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cmd_q            <= '0;
      pc_q             <= '0;
      src0_q           <= '0;
      src1_q           <= '0;
      dest_q           <= '0;
      wb_q             <= 1'b0;
      result_q         <= '0;
      branch_addr_q    <= '0;
      idt_strobe_q     <= 1'b0;
      psr_strobe_q     <= 1'b0;
      reload_pending_q <= 1'b0;
    end else begin
      // The strobes are single-cycle. They fall on the edge after they rise.
      idt_strobe_q <= 1'b0;
      psr_strobe_q <= 1'b0;

      if (accept) begin
        cmd_q  <= iPREVIOUS_CMD;
        pc_q   <= iPREVIOUS_PC + P_PC_INC;
        src0_q <= iPREVIOUS_SOURCE0;
        src1_q <= iPREVIOUS_SOURCE1;
        dest_q <= iPREVIOUS_DESTINATION;
        wb_q   <= iPREVIOUS_WRITEBACK;
      end

      if (exec_commit) begin
        result_q         <= iSYSREG_OUT;
        branch_addr_q    <= iSYSREG_RELOAD_ADDR;
        idt_strobe_q     <= iSYSREG_IDT_VALID;
        psr_strobe_q     <= iSYSREG_PSR_VALID;
        // An illegal IDT+PSR combination still yields exactly one reload.
        reload_pending_q <= iSYSREG_IDT_VALID | iSYSREG_PSR_VALID;
      end

      if ((state == WB && iEVENT_FLUSH) || (state == RELOAD && iBRANCH_ACK)) begin
        reload_pending_q <= 1'b0;
      end
    end
  end

  assign oPREVIOUS_LOCK    = (state != IDLE);
  assign oSYSREG_CMD       = cmd_q;
  assign oSYSREG_PC        = pc_q;
  assign oSYSREG_SOURCE0   = src0_q;
  assign oSYSREG_SOURCE1   = src1_q;
  assign oIDT_SET_VALID    = idt_strobe_q;
  assign oPSR_SET_VALID    = psr_strobe_q;
  assign oSET_DATA         = result_q;
  assign oNEXT_VALID       = (state == WB);
  assign oNEXT_DATA        = result_q;
  assign oNEXT_DESTINATION = dest_q;
  assign oNEXT_WRITEBACK   = wb_q;
  assign oBRANCH_REQ       = (state == RELOAD);
  assign oBRANCH_ADDR      = branch_addr_q;

endmodule

// File: tb/tb_execute_sys_reg_ctrl.sv
// Testbench for execute_sys_reg_ctrl.
//
// A small combinational datapath model sits on the oSYSREG_*/iSYSREG_* ports.
// A transaction-level reference model follows what the controller must show on
// every cycle, and a negedge compare process checks every output against it.
// Directed scenarios pin the model with literal values. A randomized phase
// then exercises valid, flush, writeback stall and reload acknowledge.
module tb_execute_sys_reg_ctrl;

  localparam logic [4:0] C_BUF  = 5'd1;  // result = src0
  localparam logic [4:0] C_PS   = 5'd2;  // PSR set, result = src0
  localparam logic [4:0] C_IDT  = 5'd3;  // IDT set, result = src0
  localparam logic [4:0] C_SR1  = 5'd4;  // result = src0 + src1*4
  localparam logic [4:0] C_BOTH = 5'd5;  // illegal: both IDT and PSR

  typedef struct packed {
    logic [4:0]  cmd;
    logic [31:0] pc;   // already advanced to the next instruction
    logic [31:0] s0;
    logic [31:0] s1;
    logic [4:0]  dest;
    logic        wb;
  } txn_t;

  typedef enum {PH_IDLE, PH_EXEC, PH_WB, PH_RELOAD} phase_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, prev_valid, prev_wb, next_lock, branch_ack;
  logic [4:0]  prev_cmd, prev_dest;
  logic [31:0] prev_pc, prev_src0, prev_src1;

  logic        prev_lock, idt_set, psr_set, next_valid, next_wb, branch_req;
  logic [4:0]  sys_cmd, next_dest;
  logic [31:0] sys_pc, sys_src0, sys_src1, set_data, next_data, branch_addr;
  logic [31:0] sys_out, sys_reload;
  logic        sys_idt, sys_psr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] dp_out(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      C_SR1:                      return a + (b << 2);
      C_BUF, C_PS, C_IDT, C_BOTH: return a;
      default:                    return a ^ b;
    endcase
  endfunction

  function automatic logic dp_idt(input logic [4:0] c);
    return (c == C_IDT) || (c == C_BOTH);
  endfunction

  function automatic logic dp_psr(input logic [4:0] c);
    return (c == C_PS) || (c == C_BOTH);
  endfunction

  assign sys_out    = dp_out(sys_cmd, sys_src0, sys_src1);
  assign sys_idt    = dp_idt(sys_cmd);
  assign sys_psr    = dp_psr(sys_cmd);
  assign sys_reload = sys_pc;

  execute_sys_reg_ctrl #(.P_PC_INC(32'h4)) dut (
    .iCLOCK               (clk),
    .inRESET              (rst_n),
    .iEVENT_FLUSH         (flush),
    .iPREVIOUS_VALID      (prev_valid),
    .oPREVIOUS_LOCK       (prev_lock),
    .iPREVIOUS_CMD        (prev_cmd),
    .iPREVIOUS_PC         (prev_pc),
    .iPREVIOUS_SOURCE0    (prev_src0),
    .iPREVIOUS_SOURCE1    (prev_src1),
    .iPREVIOUS_DESTINATION(prev_dest),
    .iPREVIOUS_WRITEBACK  (prev_wb),
    .oSYSREG_CMD          (sys_cmd),
    .oSYSREG_PC           (sys_pc),
    .oSYSREG_SOURCE0      (sys_src0),
    .oSYSREG_SOURCE1      (sys_src1),
    .iSYSREG_OUT          (sys_out),
    .iSYSREG_IDT_VALID    (sys_idt),
    .iSYSREG_PSR_VALID    (sys_psr),
    .iSYSREG_RELOAD_ADDR  (sys_reload),
    .oIDT_SET_VALID       (idt_set),
    .oPSR_SET_VALID       (psr_set),
    .oSET_DATA            (set_data),
    .oNEXT_VALID          (next_valid),
    .iNEXT_LOCK           (next_lock),
    .oNEXT_DATA           (next_data),
    .oNEXT_DESTINATION    (next_dest),
    .oNEXT_WRITEBACK      (next_wb),
    .oBRANCH_REQ          (branch_req),
    .oBRANCH_ADDR         (branch_addr),
    .iBRANCH_ACK          (branch_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight instruction and the phase it is in.
  phase_t      phase;
  txn_t        t;
  logic [31:0] m_res, m_baddr;
  logic        m_idt, m_psr, m_reload;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_IDLE;
      t        <= '0;
      m_res    <= '0;
      m_baddr  <= '0;
      m_idt    <= 1'b0;
      m_psr    <= 1'b0;
      m_reload <= 1'b0;
    end else begin
      m_idt <= 1'b0;
      m_psr <= 1'b0;
      case (phase)
        PH_IDLE: if (prev_valid && !flush) begin
          t     <= '{prev_cmd, prev_pc + 32'h4, prev_src0, prev_src1, prev_dest, prev_wb};
          phase <= PH_EXEC;
        end
        PH_EXEC: if (flush) begin
          phase <= PH_IDLE;
        end else begin
          m_res    <= dp_out(t.cmd, t.s0, t.s1);
          m_baddr  <= t.pc;
          m_idt    <= dp_idt(t.cmd);
          m_psr    <= dp_psr(t.cmd);
          m_reload <= dp_idt(t.cmd) | dp_psr(t.cmd);
          phase    <= PH_WB;
        end
        PH_WB: if (flush) begin
          phase    <= PH_IDLE;
          m_reload <= 1'b0;
        end else if (!next_lock) begin
          phase <= m_reload ? PH_RELOAD : PH_IDLE;
        end
        PH_RELOAD: if (branch_ack) begin
          phase    <= PH_IDLE;
          m_reload <= 1'b0;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("lock",        prev_lock,   phase != PH_IDLE);
    check("sys_cmd",     sys_cmd,     t.cmd);
    check("sys_pc",      sys_pc,      t.pc);
    check("sys_src0",    sys_src0,    t.s0);
    check("sys_src1",    sys_src1,    t.s1);
    check("idt_strobe",  idt_set,     m_idt);
    check("psr_strobe",  psr_set,     m_psr);
    check("set_data",    set_data,    m_res);
    check("next_valid",  next_valid,  phase == PH_WB);
    check("next_data",   next_data,   m_res);
    check("next_dest",   next_dest,   t.dest);
    check("next_wb",     next_wb,     t.wb);
    check("branch_req",  branch_req,  phase == PH_RELOAD);
    check("branch_addr", branch_addr, m_baddr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    prev_valid = 1'b1;
    prev_cmd   = c;
    prev_pc    = pc;
    prev_src0  = a;
    prev_src1  = b;
    prev_dest  = d;
    prev_wb    = w;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; next_lock = 1'b0; branch_ack = 1'b0;
    issue(5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    prev_valid = 1'b0;
    #12;
    check("rst_lock", prev_lock, 0);
    check("rst_next_valid", next_valid, 0);
    check("rst_branch_req", branch_req, 0);
    #10 rst_n = 1'b1;
    step();

    // Buffer0 read: result visible two cycles after acceptance, no reload.
    issue(C_BUF, 32'h0, 32'hDEADBEEF, 32'h0, 5'd5, 1'b1);
    step(); prev_valid = 1'b0;
    check("buf_lock_exec", prev_lock, 1);
    step();
    check("buf_valid", next_valid, 1);
    check("buf_data", next_data, 32'hDEADBEEF);
    check("buf_dest", next_dest, 5);
    check("buf_lock_wb", prev_lock, 1);
    check("buf_no_strobe", {idt_set, psr_set}, 0);
    step();
    check("buf_valid_drop", next_valid, 0);
    check("buf_unlock", prev_lock, 0);
    check("buf_no_req", branch_req, 0);

    // PSR set: strobe on the EXEC->WB edge, then a reload held for three cycles.
    issue(C_PS, 32'h1000, 32'h4, 32'h0, 5'd0, 1'b0);
    step(); prev_valid = 1'b0;
    step();
    check("ps_strobe", psr_set, 1);
    check("ps_set_data", set_data, 32'h4);
    check("ps_no_idt", idt_set, 0);
    step();
    check("ps_strobe_drop", psr_set, 0);
    check("ps_req", branch_req, 1);
    check("ps_addr", branch_addr, 32'h1004);
    step(); check("ps_req_hold1", branch_req, 1);
    step(); check("ps_req_hold2", branch_req, 1);
    branch_ack = 1'b1;
    step(); branch_ack = 1'b0;
    check("ps_req_drop", branch_req, 0);
    check("ps_idle", prev_lock, 0);

    // Writeback stall: result held for four locked cycles.
    next_lock = 1'b1;
    issue(C_SR1, 32'h0, 32'hFFFF_FFF0, 32'h1, 5'd3, 1'b1);
    step(); prev_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", next_valid, 1);
      check("stall_data", next_data, 32'hFFFF_FFF4);
      step();
    end
    check("stall_valid_end", next_valid, 1);
    next_lock = 1'b0;
    step();
    check("stall_release", next_valid, 0);
    check("stall_unlock", prev_lock, 0);

    // Flush in EXEC on an IDT set: nothing commits.
    issue(C_IDT, 32'h2000, 32'h55, 32'h0, 5'd1, 1'b0);
    step(); prev_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    check("fl_no_idt", idt_set, 0);
    check("fl_no_valid", next_valid, 0);
    check("fl_unlock", prev_lock, 0);
    step();
    check("fl_no_idt2", idt_set, 0);
    check("fl_no_req", branch_req, 0);

    // Flush while in RELOAD has no effect.
    issue(C_PS, 32'h3000, 32'h7, 32'h0, 5'd0, 1'b0);
    step(); prev_valid = 1'b0;
    step(); step();
    check("rl_req", branch_req, 1);
    check("rl_addr", branch_addr, 32'h3004);
    flush = 1'b1;
    step(); flush = 1'b0;
    check("rl_req_flush", branch_req, 1);
    check("rl_lock_flush", prev_lock, 1);
    branch_ack = 1'b1;
    step(); branch_ack = 1'b0;
    check("rl_req_drop", branch_req, 0);

    // Async reset while in WB clears everything immediately.
    next_lock = 1'b1;
    issue(C_BUF, 32'h0, 32'h1234, 32'h0, 5'd9, 1'b1);
    step(); prev_valid = 1'b0;
    step();
    check("ar_valid", next_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid0", next_valid, 0);
    check("ar_data0", next_data, 0);
    check("ar_dest0", next_dest, 0);
    check("ar_lock0", prev_lock, 0);
    next_lock = 1'b0;
    step();
    #2 rst_n = 1'b1;
    issue(C_BUF, 32'h0, 32'hCAFE, 32'h0, 5'd2, 1'b1);
    step(); prev_valid = 1'b0;
    step();
    check("ar_fresh_valid", next_valid, 1);
    check("ar_fresh_data", next_data, 32'hCAFE);
    step();
    check("ar_fresh_done", next_valid, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 7);
      issue((r < 6) ? 5'(r) : 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
      prev_valid = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 15) == 0);
      next_lock  = ($urandom_range(0, 2) == 0);
      branch_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    prev_valid = 1'b0; flush = 1'b0; next_lock = 1'b0; branch_ack = 1'b1;
    repeat (5) step();
    check("drain_idle", prev_lock, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
